multicycle_main_fsm: RTL and testbench
======================================

Name: multicycle_main_fsm

Overview:
- Main control state machine for the multicycle RV32I core.
- Sequences one shared ALU, one unified instruction/data memory port and the register file across several cycles per instruction.
- Drives ALU_op into alu_decoder and all datapath mux selects and write enables.
- Waits on a memory ready handshake.

Parameters:
- RESET_PC_WRITE, 0, when 1, pc_write is allowed to assert in the first cycle after reset release; when 0, FETCH needs mem_ready before pc_write.

Ports:
- clk  input  1  core clock.
- rst_n  input  1  asynchronous active-low reset.
- opcode  input  7  instr[6:0] from the instruction register.
- funct3  input  3  instr[14:12].
- alu_zero  input  1  ALU result == 0, live this cycle.
- alu_lsb  input  1  ALU result bit 0 (slt/sltu outcome).
- mem_ready  input  1  memory completes the current request this cycle.
- mem_req  output  1  memory access request.
- mem_write  output  1  store strobe.
- adr_src  output  1  0=PC, 1=ALUOut.
- ir_write  output  1  load the instruction register and old_pc.
- pc_write  output  1  load PC from the result mux.
- reg_write  output  1  register file write enable.
- result_src  output  2  00=ALUOut, 01=mem data, 10=ALU result.
- alu_src_a  output  2  00=PC, 01=old_pc, 10=rs1.
- alu_src_b  output  2  00=rs2, 01=imm, 10=const 4.
- imm_src  output  3  000=I, 001=S, 010=B, 011=J, 100=U.
- ALU_op  output  2  00=add, 01=branch, 10=irrr, 11=ui.
- retire  output  1  one-cycle pulse when an instruction completes.
- illegal_instr  output  1  sticky trap flag.

Behaviour:
- Reset: async to FETCH; illegal_instr=0. While rst_n=0, pc_write, ir_write, reg_write, mem_write, mem_req and retire are forced to 0.
- Outputs are Moore (decoded from state), except the mem_ready and branch-taken gating noted below. imm_src is combinational from opcode in every state.
- Default in every state: ALU_op=00, result_src=00, adr_src=0, alu_src_a=00, alu_src_b=00; all enables 0.
- FETCH:
  - mem_req=1, adr_src=0, alu_src_a=00, alu_src_b=10, result_src=10.
  - ir_write=pc_write=mem_ready.
  - Stays in FETCH while mem_ready=0, then goes to DECODE.
- DECODE:
  - alu_src_a=01, alu_src_b=01 (ALUOut <= branch/jal target).
  - Next state by opcode:
    - 0000011/0100011 -> MEMADR
    - 0110011 -> EXECR
    - 0010011 -> EXECI
    - 1100011 -> BRANCH
    - 1101111 -> JAL
    - 1100111 -> JALR
    - 0110111/0010111 -> UI
    - anything else -> TRAP
- MEMADR: alu_src_a=10, alu_src_b=01. Load -> MEMREAD, store -> MEMWRITE.
- MEMREAD: mem_req=1, adr_src=1. Holds until mem_ready, then MEMWB.
- MEMWB: result_src=01, reg_write=1, then FETCH.
- MEMWRITE: mem_req=mem_write=1, adr_src=1. Both stay held, with address stable, until mem_ready, then FETCH.
- EXECR: alu_src_a=10, alu_src_b=00, ALU_op=10, then ALUWB.
- EXECI: same as EXECR but alu_src_b=01, then ALUWB.
- ALUWB: reg_write=1, result_src=00, then FETCH.
- BRANCH:
  - alu_src_a=10, alu_src_b=00, ALU_op=01, result_src=00, pc_write=taken.
  - taken by funct3: 000=zero; 001=!zero; 100/110=lsb; 101/111=!lsb.
  - funct3 010/011 -> TRAP with pc_write=0; otherwise -> FETCH.
- JAL: alu_src_a=01, alu_src_b=10, result_src=00, pc_write=1 (PC <= ALUOut target), then ALUWB (rd <= old_pc+4).
- JALR: alu_src_a=10, alu_src_b=01 (ALUOut <= rs1+imm), then JAL. The datapath clears bit 0 of the target.
- UI: alu_src_a=01, alu_src_b=01, ALU_op=11, then ALUWB.
- TRAP: all enables 0, illegal_instr=1, absorbing until reset.
- retire=1 on the final cycle of each instruction: MEMWB, MEMWRITE with mem_ready, ALUWB, BRANCH without trap.
- Latencies with mem_ready tied to 1:
  - ALU/UI: 4 cycles
  - branch: 3
  - store: 4
  - load: 5
  - jal: 4
  - jalr: 5
- Reset mid-access: the state is abandoned immediately. mem_req drops in the reset cycle; no partial write is committed.

Decomposition:
- Package mc_ctrl_pkg holds:
  - state enum (4-bit)
  - opcode constants
  - ALU_op constants (shared with alu_decoder)
  - result_src, alu_src_a, alu_src_b and imm_src encodings
- Sub-module instr_imm_decoder: opcode -> imm_src, combinational.

Test Plan:
- add x3,x1,x2 (0x002081B3), mem_ready=1 -> FETCH,DECODE,EXECR,ALUWB. ALU_op=10 in EXECR; reg_write=1 and retire=1 in cycle 4.
- lw with mem_ready low for 3 cycles in MEMREAD -> mem_req and adr_src=1 held 4 cycles. MEMWB follows with result_src=01, reg_write=1.
- beq with alu_zero=1, then bne with alu_zero=1 -> pc_write=1, then 0, in the BRANCH cycle; both return to FETCH after 3 cycles.
- jalr -> JALR, JAL, ALUWB. pc_write=1 only in JAL; reg_write=1 only in ALUWB.
- opcode 0x7F, or branch with funct3=010 -> TRAP. illegal_instr stays 1 for 20 cycles; no enable asserts; rst_n pulse clears it.
- rst_n asserted during MEMWRITE -> mem_write=0 at once. After release: FETCH, mem_req=1, adr_src=0.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control path: FSM states, opcodes, mux selects, ALU_op.
// Pure declarations plus a branch-condition helper; no state, no latency, no flow control.
// ALU_op values are also consumed by alu_decoder, so keep them in sync with it.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_JALR     = 4'd11,
        S_UI       = 4'd12,
        S_TRAP     = 4'd13
    } state_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [1:0] ALU_OP_ADD    = 2'b00;
    localparam logic [1:0] ALU_OP_BRANCH = 2'b01;
    localparam logic [1:0] ALU_OP_IRRR   = 2'b10;
    localparam logic [1:0] ALU_OP_UI     = 2'b11;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_MEM    = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    // Signed compares come back from the ALU as result bit 0 (slt/sltu), equality as zero.
    function automatic logic branch_taken(input logic [2:0] funct3,
                                          input logic       zero,
                                          input logic       lsb);
        case (funct3)
            3'b000:          branch_taken = zero;
            3'b001:          branch_taken = !zero;
            3'b100, 3'b110:  branch_taken = lsb;
            3'b101, 3'b111:  branch_taken = !lsb;
            default:         branch_taken = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/instr_imm_decoder.sv
// Selects the immediate format from the opcode.
// Purely combinational, zero latency; no flow control.
// Opcodes with no immediate fall back to the I format.
module instr_imm_decoder
    import mc_ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    output logic [2:0] imm_src
);

    always_comb begin
        case (opcode)
            OP_STORE:         imm_src = IMM_S;
            OP_BRANCH:        imm_src = IMM_B;
            OP_JAL:           imm_src = IMM_J;
            OP_LUI, OP_AUIPC: imm_src = IMM_U;
            default:          imm_src = IMM_I;
        endcase
    end

endmodule

// File: rtl/multicycle_main_fsm.sv
// Main control FSM of the multicycle RV32I core: sequences ALU, unified memory port and regfile.
// Moore outputs per state; 3 cycles (branch) to 5 cycles (load/jalr) per instruction with mem_ready=1.
// FETCH, MEMREAD and MEMWRITE hold with request and address stable until mem_ready.
module multicycle_main_fsm
    import mc_ctrl_pkg::*;
#(
    parameter bit RESET_PC_WRITE = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       alu_zero,
    input  logic       alu_lsb,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_write,
    output logic       adr_src,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] imm_src,
    output logic [1:0] ALU_op,
    output logic       retire,
    output logic       illegal_instr
);

    state_e state_q, state_d;
    logic   first_q;
    logic   br_bad;
    logic   mem_req_raw, mem_write_raw, ir_write_raw, pc_write_raw, reg_write_raw, retire_raw;

    // funct3 010/011 are not branch encodings in RV32I.
    assign br_bad = (funct3[2:1] == 2'b01);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            first_q <= 1'b1;
        end else begin
            state_q <= state_d;
            first_q <= 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:    if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_R:              state_d = S_EXECR;
                    OP_IMM:            state_d = S_EXECI;
                    OP_BRANCH:         state_d = S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
                    OP_JALR:           state_d = S_JALR;
                    OP_LUI, OP_AUIPC:  state_d = S_UI;
                    default:           state_d = S_TRAP;
                endcase
            end
            S_MEMADR:   state_d = (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
            S_EXECR:    state_d = S_ALUWB;
            S_EXECI:    state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BRANCH:   state_d = br_bad ? S_TRAP : S_FETCH;
            S_JAL:      state_d = S_ALUWB;
            S_JALR:     state_d = S_JAL;
            S_UI:       state_d = S_ALUWB;
            S_TRAP:     state_d = S_TRAP;
            default:    state_d = S_TRAP;
        endcase
    end

    always_comb begin
        mem_req_raw   = 1'b0;
        mem_write_raw = 1'b0;
        ir_write_raw  = 1'b0;
        pc_write_raw  = 1'b0;
        reg_write_raw = 1'b0;
        retire_raw    = 1'b0;
        adr_src       = 1'b0;
        result_src    = RES_ALUOUT;
        alu_src_a     = SRCA_PC;
        alu_src_b     = SRCB_RS2;
        ALU_op        = ALU_OP_ADD;
        case (state_q)
            S_FETCH: begin
                mem_req_raw  = 1'b1;
                alu_src_b    = SRCB_FOUR;
                result_src   = RES_ALU;
                ir_write_raw = mem_ready;
                pc_write_raw = mem_ready | (RESET_PC_WRITE & first_q);
            end
            S_DECODE: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
            end
            S_MEMADR, S_JALR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
            end
            S_MEMREAD: begin
                mem_req_raw = 1'b1;
                adr_src     = 1'b1;
            end
            S_MEMWB: begin
                result_src    = RES_MEM;
                reg_write_raw = 1'b1;
                retire_raw    = 1'b1;
            end
            S_MEMWRITE: begin
                mem_req_raw   = 1'b1;
                mem_write_raw = 1'b1;
                adr_src       = 1'b1;
                retire_raw    = mem_ready;
            end
            S_EXECR: begin
                alu_src_a = SRCA_RS1;
                ALU_op    = ALU_OP_IRRR;
            end
            S_EXECI: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                ALU_op    = ALU_OP_IRRR;
            end
            S_ALUWB: begin
                reg_write_raw = 1'b1;
                retire_raw    = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a    = SRCA_RS1;
                ALU_op       = ALU_OP_BRANCH;
                pc_write_raw = !br_bad && branch_taken(funct3, alu_zero, alu_lsb);
                retire_raw   = !br_bad;
            end
            S_JAL: begin
                alu_src_a    = SRCA_OLDPC;
                alu_src_b    = SRCB_FOUR;
                pc_write_raw = 1'b1;
            end
            S_UI: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                ALU_op    = ALU_OP_UI;
            end
            default: ;
        endcase
    end

    // The reset state decodes as FETCH, so strobes are gated by rst_n to stay quiet during reset.
    assign mem_req       = mem_req_raw   & rst_n;
    assign mem_write     = mem_write_raw & rst_n;
    assign ir_write      = ir_write_raw  & rst_n;
    assign pc_write      = pc_write_raw  & rst_n;
    assign reg_write     = reg_write_raw & rst_n;
    assign retire        = retire_raw    & rst_n;
    assign illegal_instr = (state_q == S_TRAP);

    instr_imm_decoder u_imm_dec (
        .opcode  (opcode),
        .imm_src (imm_src)
    );

endmodule

// File: tb/tb_multicycle_main_fsm.sv
// Directed per-cycle vectors for multicycle_main_fsm, plus a trap-hold and reset sequence.
module tb_multicycle_main_fsm;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       alu_zero, alu_lsb, mem_ready;
    logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, retire, illegal_instr;
    logic [1:0] result_src, alu_src_a, alu_src_b, ALU_op;
    logic [2:0] imm_src;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    multicycle_main_fsm dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .opcode        (opcode),
        .funct3        (funct3),
        .alu_zero      (alu_zero),
        .alu_lsb       (alu_lsb),
        .mem_ready     (mem_ready),
        .mem_req       (mem_req),
        .mem_write     (mem_write),
        .adr_src       (adr_src),
        .ir_write      (ir_write),
        .pc_write      (pc_write),
        .reg_write     (reg_write),
        .result_src    (result_src),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .imm_src       (imm_src),
        .ALU_op        (ALU_op),
        .retire        (retire),
        .illegal_instr (illegal_instr)
    );

    // {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, retire, illegal,
    //  result_src, alu_src_a, alu_src_b, ALU_op}
    localparam logic [15:0] E_RST        = 16'b0000_0000_10_00_10_00;
    localparam logic [15:0] E_FETCH_W    = 16'b1000_0000_10_00_10_00;
    localparam logic [15:0] E_FETCH      = 16'b1001_1000_10_00_10_00;
    localparam logic [15:0] E_DECODE     = 16'b0000_0000_00_01_01_00;
    localparam logic [15:0] E_MEMADR     = 16'b0000_0000_00_10_01_00;
    localparam logic [15:0] E_MEMREAD    = 16'b1010_0000_00_00_00_00;
    localparam logic [15:0] E_MEMWB      = 16'b0000_0110_01_00_00_00;
    localparam logic [15:0] E_MEMWRITE_W = 16'b1110_0000_00_00_00_00;
    localparam logic [15:0] E_MEMWRITE   = 16'b1110_0010_00_00_00_00;
    localparam logic [15:0] E_EXECR      = 16'b0000_0000_00_10_00_10;
    localparam logic [15:0] E_EXECI      = 16'b0000_0000_00_10_01_10;
    localparam logic [15:0] E_ALUWB      = 16'b0000_0110_00_00_00_00;
    localparam logic [15:0] E_BR_T       = 16'b0000_1010_00_10_00_01;
    localparam logic [15:0] E_BR_N       = 16'b0000_0010_00_10_00_01;
    localparam logic [15:0] E_BR_TRAP    = 16'b0000_0000_00_10_00_01;
    localparam logic [15:0] E_JAL        = 16'b0000_1000_00_01_10_00;
    localparam logic [15:0] E_JALR       = 16'b0000_0000_00_10_01_00;
    localparam logic [15:0] E_UI         = 16'b0000_0000_00_01_01_11;
    localparam logic [15:0] E_TRAP       = 16'b0000_0001_00_00_00_00;

    localparam logic [6:0] LD  = 7'b0000011, ST  = 7'b0100011, RR  = 7'b0110011, RI = 7'b0010011;
    localparam logic [6:0] BR  = 7'b1100011, JL  = 7'b1101111, JR  = 7'b1100111, AU = 7'b0010111;
    localparam logic [6:0] BAD = 7'b1111111;

    typedef struct {
        logic        rst_n;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        z;
        logic        lsb;
        logic        mr;
        logic [15:0] exp;
        logic [2:0]  imm;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic [6:0] op, input logic [2:0] f3, input logic z,
                       input logic lsb, input logic mr, input logic [15:0] exp, input logic [2:0] imm);
        vec_t v;
        v.rst_n = r; v.op = op; v.f3 = f3; v.z = z; v.lsb = lsb; v.mr = mr; v.exp = exp; v.imm = imm;
        vecs.push_back(v);
    endtask

    function automatic logic [15:0] got_word();
        return {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, retire, illegal_instr,
                result_src, alu_src_a, alu_src_b, ALU_op};
    endfunction

    task automatic check(input string name, input logic [15:0] exp, input logic [2:0] exp_imm);
        logic [15:0] g;
        g = got_word();
        total++;
        if (g !== exp) begin
            bad++;
            $display("FAIL %s outputs got %b want %b", name, g, exp);
        end
        total++;
        if (imm_src !== exp_imm) begin
            bad++;
            $display("FAIL %s imm_src got %b want %b", name, imm_src, exp_imm);
        end
    endtask

    task automatic drive(input logic r, input logic [6:0] op, input logic [2:0] f3,
                         input logic z, input logic lsb, input logic mr);
        rst_n = r; opcode = op; funct3 = f3; alu_zero = z; alu_lsb = lsb; mem_ready = mr;
    endtask

    initial begin
        // reset
        add(0, RR, 0, 0, 0, 1, E_RST, 3'b000);
        // add: 4 cycles
        add(1, RR, 0, 0, 0, 1, E_FETCH, 3'b000);
        add(1, RR, 0, 0, 0, 1, E_DECODE, 3'b000);
        add(1, RR, 0, 0, 0, 1, E_EXECR, 3'b000);
        add(1, RR, 0, 0, 0, 1, E_ALUWB, 3'b000);
        // addi
        add(1, RI, 0, 0, 0, 1, E_FETCH, 3'b000);
        add(1, RI, 0, 0, 0, 1, E_DECODE, 3'b000);
        add(1, RI, 0, 0, 0, 1, E_EXECI, 3'b000);
        add(1, RI, 0, 0, 0, 1, E_ALUWB, 3'b000);
        // lw with 3 wait cycles in MEMREAD
        add(1, LD, 2, 0, 0, 1, E_FETCH, 3'b000);
        add(1, LD, 2, 0, 0, 1, E_DECODE, 3'b000);
        add(1, LD, 2, 0, 0, 1, E_MEMADR, 3'b000);
        for (int i = 0; i < 3; i++) add(1, LD, 2, 0, 0, 0, E_MEMREAD, 3'b000);
        add(1, LD, 2, 0, 0, 1, E_MEMREAD, 3'b000);
        add(1, LD, 2, 0, 0, 1, E_MEMWB, 3'b000);
        // sw, no wait: 4 cycles
        add(1, ST, 2, 0, 0, 1, E_FETCH, 3'b001);
        add(1, ST, 2, 0, 0, 1, E_DECODE, 3'b001);
        add(1, ST, 2, 0, 0, 1, E_MEMADR, 3'b001);
        add(1, ST, 2, 0, 0, 1, E_MEMWRITE, 3'b001);
        // fetch stall
        add(1, RR, 0, 0, 0, 0, E_FETCH_W, 3'b000);
        add(1, RR, 0, 0, 0, 0, E_FETCH_W, 3'b000);
        add(1, RR, 0, 0, 0, 1, E_FETCH, 3'b000);
        add(1, RR, 0, 0, 0, 1, E_DECODE, 3'b000);
        add(1, RR, 0, 0, 0, 1, E_EXECR, 3'b000);
        add(1, RR, 0, 0, 0, 1, E_ALUWB, 3'b000);
        // beq taken, bne not taken, blt taken (lsb), bgeu not taken (lsb)
        add(1, BR, 0, 1, 0, 1, E_FETCH, 3'b010);
        add(1, BR, 0, 1, 0, 1, E_DECODE, 3'b010);
        add(1, BR, 0, 1, 0, 1, E_BR_T, 3'b010);
        add(1, BR, 1, 1, 0, 1, E_FETCH, 3'b010);
        add(1, BR, 1, 1, 0, 1, E_DECODE, 3'b010);
        add(1, BR, 1, 1, 0, 1, E_BR_N, 3'b010);
        add(1, BR, 4, 0, 1, 1, E_FETCH, 3'b010);
        add(1, BR, 4, 0, 1, 1, E_DECODE, 3'b010);
        add(1, BR, 4, 0, 1, 1, E_BR_T, 3'b010);
        add(1, BR, 7, 0, 1, 1, E_FETCH, 3'b010);
        add(1, BR, 7, 0, 1, 1, E_DECODE, 3'b010);
        add(1, BR, 7, 0, 1, 1, E_BR_N, 3'b010);
        // jalr: 5 cycles
        add(1, JR, 0, 0, 0, 1, E_FETCH, 3'b000);
        add(1, JR, 0, 0, 0, 1, E_DECODE, 3'b000);
        add(1, JR, 0, 0, 0, 1, E_JALR, 3'b000);
        add(1, JR, 0, 0, 0, 1, E_JAL, 3'b000);
        add(1, JR, 0, 0, 0, 1, E_ALUWB, 3'b000);
        // jal: 4 cycles
        add(1, JL, 0, 0, 0, 1, E_FETCH, 3'b011);
        add(1, JL, 0, 0, 0, 1, E_DECODE, 3'b011);
        add(1, JL, 0, 0, 0, 1, E_JAL, 3'b011);
        add(1, JL, 0, 0, 0, 1, E_ALUWB, 3'b011);
        // auipc
        add(1, AU, 0, 0, 0, 1, E_FETCH, 3'b100);
        add(1, AU, 0, 0, 0, 1, E_DECODE, 3'b100);
        add(1, AU, 0, 0, 0, 1, E_UI, 3'b100);
        add(1, AU, 0, 0, 0, 1, E_ALUWB, 3'b100);
        // sw stalled, then reset mid-write
        add(1, ST, 2, 0, 0, 1, E_FETCH, 3'b001);
        add(1, ST, 2, 0, 0, 1, E_DECODE, 3'b001);
        add(1, ST, 2, 0, 0, 1, E_MEMADR, 3'b001);
        add(1, ST, 2, 0, 0, 0, E_MEMWRITE_W, 3'b001);
        add(1, ST, 2, 0, 0, 0, E_MEMWRITE_W, 3'b001);
        add(0, ST, 2, 0, 0, 0, E_RST, 3'b001);
        add(1, ST, 2, 0, 0, 0, E_FETCH_W, 3'b001);
        // branch with funct3=010 traps
        add(1, BR, 2, 1, 1, 1, E_FETCH, 3'b010);
        add(1, BR, 2, 1, 1, 1, E_DECODE, 3'b010);
        add(1, BR, 2, 1, 1, 1, E_BR_TRAP, 3'b010);
        add(1, BR, 2, 1, 1, 1, E_TRAP, 3'b010);

        foreach (vecs[i]) begin
            drive(vecs[i].rst_n, vecs[i].op, vecs[i].f3, vecs[i].z, vecs[i].lsb, vecs[i].mr);
            #1;
            check($sformatf("vec%0d", i), vecs[i].exp, vecs[i].imm);
            @(posedge clk);
            #1;
        end

        // TRAP is absorbing regardless of inputs
        for (int i = 0; i < 20; i++) begin
            drive(1, 7'($urandom), 3'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            #1;
            total++;
            if (got_word() !== E_TRAP) begin
                bad++;
                $display("FAIL trap_hold%0d outputs got %b want %b", i, got_word(), E_TRAP);
            end
            @(posedge clk);
            #1;
        end

        // rst_n pulse clears the trap
        drive(0, RR, 0, 0, 0, 1);
        #1;
        check("trap_rst", E_RST, 3'b000);
        @(posedge clk);
        #1;
        drive(1, RR, 0, 0, 0, 0);
        #1;
        check("trap_rel", E_FETCH_W, 3'b000);
        @(posedge clk);
        #1;

        // undefined opcode traps from DECODE
        drive(1, BAD, 0, 0, 0, 1);
        #1;
        check("bad_fetch", E_FETCH, 3'b000);
        @(posedge clk);
        #1;
        check("bad_decode", E_DECODE, 3'b000);
        @(posedge clk);
        #1;
        check("bad_trap", E_TRAP, 3'b000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
